timer_bus_master: RTL and testbench

Bus master that sits directly upstream of the timer peripheral and drives its req/gnt handshake bus. It accepts single read/write commands from a valid/ready command port and runs each one on the bus. It enforces grant and release timeouts, captures read data, and returns one response per command. Only one transaction is outstanding at a time.

---
 rtl/timer_bus_master_if.sv | 23 ++
 rtl/timer_bus_master.sv | 177 +++++++++++++++++
 tb/tb_timer_bus_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bus_master_if.sv
// Request/grant bus between the timer bus master and the timer peripheral.
// The master drives req/addr/wdata/write_en; the peripheral answers with gnt/rdata.
interface timer_bus_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, addr, wdata, write_en,
        input  gnt, rdata
    );

    modport slave (
        input  req, addr, wdata, write_en,
        output gnt, rdata
    );
endinterface

// File: rtl/timer_bus_master.sv
// Single-outstanding req/gnt bus master for the timer peripheral with grant/release timeouts.
// Optional TIMER_MASTER_STATS_EN builds saturating transaction and error counters.
module timer_bus_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int GNT_TIMEOUT = 8,
    parameter int REL_TIMEOUT = 4,
    parameter int RDATA_DLY   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic [3:0]            rsp_gnt_lat,
    timer_bus_master_if.master    bus,
    output logic [15:0]           txn_count,
    output logic [15:0]           err_count
);
    typedef enum logic [2:0] {IDLE, REQ, DATA, RELEASE, RESP} state_t;

    localparam logic [3:0] GNT_TO = 4'(GNT_TIMEOUT);
    localparam logic [3:0] REL_TO = 4'(REL_TIMEOUT);
    localparam logic [1:0] DLY    = 2'(RDATA_DLY);

    state_t                state_reg;
    logic [3:0]            wait_cnt_reg;
    logic [3:0]            rel_cnt_reg;
    logic [1:0]            dly_cnt_reg;
    logic                  req_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  write_en_reg;
    logic                  cmd_ready_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic [1:0]            rsp_err_reg;
    logic [3:0]            rsp_gnt_lat_reg;
    logic                  rsp_hs;

    assign rsp_hs = rsp_valid_reg && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            rel_cnt_reg     <= '0;
            dly_cnt_reg     <= '0;
            req_reg         <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            write_en_reg    <= 1'b0;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= '0;
            rsp_gnt_lat_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A lingering gnt from the previous transaction holds off new commands
                    cmd_ready_reg <= !bus.gnt;
                    if (cmd_valid && cmd_ready_reg) begin
                        cmd_ready_reg   <= 1'b0;
                        addr_reg        <= cmd_addr;
                        wdata_reg       <= cmd_wdata;
                        write_en_reg    <= cmd_write;
                        req_reg         <= 1'b1;
                        wait_cnt_reg    <= 4'd1;
                        rsp_err_reg     <= 2'b00;
                        rsp_rdata_reg   <= '0;
                        rsp_gnt_lat_reg <= '0;
                        state_reg       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.gnt) begin
                        // wait_cnt never exceeds GNT_TIMEOUT (<= 15), so this is already saturated
                        rsp_gnt_lat_reg <= wait_cnt_reg;
                        if (!write_en_reg && (RDATA_DLY > 0)) begin
                            dly_cnt_reg <= 2'd1;
                            state_reg   <= DATA;
                        end else begin
                            if (!write_en_reg) begin
                                rsp_rdata_reg <= bus.rdata;
                            end
                            req_reg     <= 1'b0;
                            rel_cnt_reg <= 4'd1;
                            state_reg   <= RELEASE;
                        end
                    end else if (wait_cnt_reg == GNT_TO) begin
                        // Peripheral cancels on req falling before gnt, so skip RELEASE
                        req_reg       <= 1'b0;
                        rsp_err_reg   <= 2'b01;
                        rsp_rdata_reg <= '0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                DATA: begin
                    if (dly_cnt_reg == DLY) begin
                        rsp_rdata_reg <= bus.rdata;
                        req_reg       <= 1'b0;
                        rel_cnt_reg   <= 4'd1;
                        state_reg     <= RELEASE;
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg + 2'd1;
                    end
                end
                RELEASE: begin
                    if (!bus.gnt) begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (rel_cnt_reg == REL_TO) begin
                        rsp_err_reg   <= 2'b10;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        rel_cnt_reg <= rel_cnt_reg + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rsp_rdata_reg;
    assign rsp_err      = rsp_err_reg;
    assign rsp_gnt_lat  = rsp_gnt_lat_reg;
    assign bus.req      = req_reg;
    assign bus.addr     = addr_reg;
    assign bus.wdata    = wdata_reg;
    assign bus.write_en = write_en_reg;

`ifdef TIMER_MASTER_STATS_EN
    logic [15:0] txn_count_reg;
    logic [15:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_count_reg <= '0;
            err_count_reg <= '0;
        end else if (rsp_hs) begin
            if (txn_count_reg != 16'hFFFF) begin
                txn_count_reg <= txn_count_reg + 16'd1;
            end
            if ((rsp_err_reg != 2'b00) && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign txn_count = txn_count_reg;
    assign err_count = err_count_reg;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
    assign txn_count = 16'd0;
    assign err_count = 16'd0;
`endif
endmodule

// File: tb/tb_timer_bus_master.sv
// Self-checking bench for timer_bus_master: table vectors, hand sequences and random traffic
// against a transaction-level peripheral/response model.
module tb_timer_bus_master;
    localparam int GT  = 8;
    localparam int RT  = 4;
    localparam int DLY = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [3:0]  rsp_gnt_lat;
    logic [15:0] txn_count;
    logic [15:0] err_count;

    timer_bus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    timer_bus_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .GNT_TIMEOUT(GT), .REL_TIMEOUT(RT), .RDATA_DLY(DLY)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_gnt_lat(rsp_gnt_lat),
        .bus(bus),
        .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_txn = 0;
    int exp_errc = 0;
    int txn_no = 0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          g;     // req-high cycle in which gnt rises (0 = never)
        int          h;     // cycles gnt stays high after req falls
        logic [31:0] rv;
        int          rw;    // cycles rsp_ready is held low
        bit          pend;  // keep cmd_valid asserted after accept
        logic [1:0]  e_err;
        logic [3:0]  e_lat;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
        end
    endtask

    // Transaction-level expectation derived from the handshake rules
    function automatic void model(input bit wr, input int g, input int h, input logic [31:0] rv,
                                  output logic [1:0] e, output logic [3:0] lat,
                                  output logic [31:0] rd, output int hi);
        if (g < 1 || g > GT) begin
            e = 2'b01; lat = 4'd0; rd = 32'd0; hi = GT;
        end else begin
            lat = 4'(g);
            hi  = wr ? g : g + DLY;
            rd  = wr ? 32'd0 : rv;
            e   = (h >= RT) ? 2'b10 : 2'b00;
        end
    endfunction

    task automatic stats_chk();
`ifdef TIMER_MASTER_STATS_EN
        chk("txn_count", 64'(txn_count), 64'(exp_txn));
        chk("err_count", 64'(err_count), 64'(exp_errc));
`else
        chk("txn_count", 64'(txn_count), 64'd0);
        chk("err_count", 64'(err_count), 64'd0);
`endif
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] wd, output bit ok);
        bit acc;
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        acc = cmd_ready; n = 0; ok = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1;
            if (acc) begin ok = 1'b1; break; end
            acc = cmd_ready;
            n++;
        end
        chk("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic run_txn(input vec_t v);
        bit ok, granted, got, done, hs, gv;
        int req_hi, rel, stall, cyc, exp_hi;
        logic [1:0] m_e; logic [3:0] m_l; logic [31:0] m_r;
        model(v.wr, v.g, v.h, v.rv, m_e, m_l, m_r, exp_hi);
        send_cmd(v.wr, v.a, v.wd, ok);
        cmd_valid = v.pend;
        chk("req_after_accept", 64'(bus.req), 64'd1);
        granted = 0; got = 0; done = 0; req_hi = 0; rel = 0; stall = 0; cyc = 0;
        while (!(done && !(granted && rel < v.h))) begin
            if (cyc >= 120) begin
                errors++;
                $display("FAIL txn_timeout actual=%0d cycles required=response", cyc);
                break;
            end
            if (bus.req) begin
                req_hi++;
                if (req_hi == 1) begin
                    chk("bus_addr", 64'(bus.addr), 64'(v.a));
                    chk("bus_write_en", 64'(bus.write_en), 64'(v.wr));
                    if (v.wr) chk("bus_wdata", 64'(bus.wdata), 64'(v.wd));
                end
                gv = (v.g != 0) && (req_hi >= v.g);
                granted |= gv;
                bus.rdata = (!v.wr && v.g != 0 && req_hi == v.g + DLY) ? v.rv : $urandom;
            end else begin
                gv = granted && (rel < v.h);
                if (granted) rel++;
                bus.rdata = $urandom;
            end
            bus.gnt = gv;
            if (gv) chk("cmd_ready_while_gnt", 64'(cmd_ready), 64'd0);
            if (rsp_valid) begin
                if (done) begin
                    chk("single_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    if (!got) chk("req_high_cycles", 64'(req_hi), 64'(exp_hi));
                    got = 1;
                    chk("rsp_err", 64'(rsp_err), 64'(v.e_err));
                    chk("rsp_gnt_lat", 64'(rsp_gnt_lat), 64'(v.e_lat));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.e_rd));
                    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    chk("req_low_in_resp", 64'(bus.req), 64'd0);
                end
            end
            rsp_ready = (rsp_valid && !done) ? (stall >= v.rw) : 1'b0;
            if (rsp_valid && !done) stall++;
            hs = rsp_valid && rsp_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                done = 1; rsp_ready = 1'b0;
                exp_txn++;
                if (v.e_err != 2'b00) exp_errc++;
                chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);
            end
        end
        bus.gnt = 1'b0;
        rsp_ready = 1'b0;
        stats_chk();
        $display("txn %0d wr=%0b addr=%08h g=%0d h=%0d err=%0d lat=%0d rdata=%08h",
                 txn_no, v.wr, v.a, v.g, v.h, rsp_err, rsp_gnt_lat, rsp_rdata);
        txn_no++;
    endtask

    initial begin
        vec_t rv_v;
        bit ok;
        logic [1:0] m_e; logic [3:0] m_l; logic [31:0] m_r; int m_hi;

        //          wr  addr   wdata         g  h  rdata         rw pend err   lat rdata
        vecs[0] = '{1, 32'h04, 32'h1234,     2, 1, 32'h0,        0, 0, 2'b00, 2, 32'h0};
        vecs[1] = '{0, 32'h04, 32'h0,        2, 1, 32'hAB,       0, 0, 2'b00, 2, 32'hAB};
        vecs[2] = '{0, 32'h08, 32'h0,        0, 0, 32'h77,       0, 0, 2'b01, 0, 32'h0};
        vecs[3] = '{1, 32'h0C, 32'h5A5A,     3, 6, 32'h0,        1, 0, 2'b10, 3, 32'h0};
        vecs[4] = '{0, 32'h10, 32'h0,        1, 6, 32'h55,       0, 0, 2'b10, 1, 32'h55};
        vecs[5] = '{1, 32'h14, 32'hCAFE,     8, 0, 32'h0,        0, 0, 2'b00, 8, 32'h0};
        vecs[6] = '{0, 32'h18, 32'h0,        9, 0, 32'h11,       2, 0, 2'b01, 0, 32'h0};
        vecs[7] = '{1, 32'h1C, 32'hBEEF,     1, 3, 32'h0,        5, 1, 2'b00, 1, 32'h0};
        vecs[8] = '{0, 32'h20, 32'h0,        4, 4, 32'hDEADBEEF, 0, 0, 2'b10, 4, 32'hDEADBEEF};
        vecs[9] = '{0, 32'h24, 32'h0,        1, 0, 32'h1,        0, 0, 2'b00, 1, 32'h1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bus.gnt = 1'b0; bus.rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(bus.req), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_addr", 64'(bus.addr), 64'd0);
        chk("rst_write_en", 64'(bus.write_en), 64'd0);
        stats_chk();
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Spurious gnt while idle only blocks cmd_ready
        repeat (2) @(posedge clk);
        #1;
        bus.gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("spurious_gnt_ready", 64'(cmd_ready), 64'd0);
        chk("spurious_gnt_rsp", 64'(rsp_valid), 64'd0);
        bus.gnt = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_gnt_low", 64'(cmd_ready), 64'd1);

        // Reset while waiting for grant aborts without a response
        send_cmd(1'b0, 32'h40, 32'h0, ok);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("req_before_abort", 64'(bus.req), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_req", 64'(bus.req), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_txn = 0; exp_errc = 0;
        stats_chk();
        begin
            bit seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                seen |= rsp_valid;
            end
            chk("abort_no_rsp", 64'(seen), 64'd0);
        end

        // Three good plus one grant timeout after the abort
        run_txn('{1, 32'h50, 32'h1, 2, 0, 32'h0, 0, 0, 2'b00, 2, 32'h0});
        run_txn('{0, 32'h54, 32'h0, 3, 1, 32'h99, 0, 0, 2'b00, 3, 32'h99});
        run_txn('{1, 32'h58, 32'h2, 1, 2, 32'h0, 1, 0, 2'b00, 1, 32'h0});
        run_txn('{0, 32'h5C, 32'h0, 0, 0, 32'h0, 0, 0, 2'b01, 0, 32'h0});

        // Randomized traffic checked against the transaction model
        for (int i = 0; i < 24; i++) begin
            rv_v.wr   = 1'($urandom_range(0, 1));
            rv_v.a    = $urandom;
            rv_v.wd   = $urandom;
            rv_v.g    = int'($urandom_range(0, 10));
            rv_v.h    = int'($urandom_range(0, 6));
            rv_v.rv   = $urandom;
            rv_v.rw   = int'($urandom_range(0, 3));
            rv_v.pend = 1'b0;
            model(rv_v.wr, rv_v.g, rv_v.h, rv_v.rv, m_e, m_l, m_r, m_hi);
            rv_v.e_err = m_e; rv_v.e_lat = m_l; rv_v.e_rd = m_r;
            run_txn(rv_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
